// File: rtl/vec_dot_product_pipe_if.sv
// Purpose: bundles the element load/read-back port and the start/busy/done
//          result port of vec_dot_product_pipe into one interface.
// Latency: n/a (wires only).
// Backpressure: n/a; writes and start are dropped by the slave while busy.
//
// Signals:
//   we_a / we_b / wr_addr / wr_data : element writes into vector A and/or B
//   rd_addr -> rd_a / rd_b          : combinational element read-back
//   signed_mode / start             : computation request
//   busy / done / result / result_valid / ovf : computation status and result
// Modports: master = loader/display side, slave = dot-product unit.

interface vec_dot_product_pipe_if #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int ACC_W = 16
);
  localparam int AW = $clog2(N);

  logic             we_a;
  logic             we_b;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;
  logic [AW-1:0]    rd_addr;
  logic [W-1:0]     rd_a;
  logic [W-1:0]     rd_b;
  logic             signed_mode;
  logic             start;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             ovf;

  modport master (
    output we_a, we_b, wr_addr, wr_data, rd_addr, signed_mode, start,
    input  rd_a, rd_b, busy, done, result, result_valid, ovf
  );

  modport slave (
    input  we_a, we_b, wr_addr, wr_data, rd_addr, signed_mode, start,
    output rd_a, rd_b, busy, done, result, result_valid, ovf
  );
endinterface

// File: rtl/vec_dot_product_pipe.sv
// Purpose: N-element dot product of two W-bit register banks, unsigned or
//          signed, wrap or saturate into ACC_W bits, 2-stage multiply/accumulate.
// Latency: start accepted at edge T0, done pulses after edge T(N+2).
// Backpressure: none queued; start and element writes are ignored while busy.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : vec_dot_product_pipe_if.slave (write port, read-back port,
//                start/busy/done handshake, result/result_valid/ovf)

module vec_dot_product_pipe #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int SAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vec_dot_product_pipe_if.slave bus
);

  localparam int AW     = $clog2(N);
  localparam int PROD_W = 2 * W;
  // Wide enough that N products of either signedness can never overflow.
  localparam int SUM_W  = 2 * W + $clog2(N) + 1;
  // One bit more than both the sum and the result so the range compares
  // below are plain signed compares whatever the relative sizes.
  localparam int EXT_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  localparam logic [AW:0]   N_L  = N[AW:0];
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  // Range bounds of the result, sign-extended to EXT_W.
  localparam logic signed [EXT_W-1:0] UMAX = {{(EXT_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic signed [EXT_W-1:0] SMAX = {{(EXT_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SMIN = {{(EXT_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};

  // Same bounds at result width, used as the clamp values.
  localparam logic [ACC_W-1:0] RES_UMAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] RES_SMAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0] RES_SMIN = {1'b1, {(ACC_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [W-1:0]      a_mem [N];
  logic [W-1:0]      b_mem [N];

  state_t            state_q;
  logic [AW-1:0]     idx_q;
  logic              mode_q;      // signed_mode latched at start
  logic [PROD_W-1:0] prod_q;      // stage-1 product register
  logic              prod_vld_q;  // prod_q holds a product still to be added
  logic [SUM_W-1:0]  acc_q;       // stage-2 accumulator
  logic              busy_q;
  logic              done_q;
  logic [ACC_W-1:0]  result_q;
  logic              result_valid_q;
  logic              ovf_q;

  // ---------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------
  logic wr_addr_ok;
  logic wr_en_a;
  logic wr_en_b;
  logic wr_any;

  // Out-of-range addresses only exist when N is not a power of two.
  assign wr_addr_ok = ({1'b0, bus.wr_addr} < N_L);
  assign wr_en_a    = bus.we_a && !busy_q && wr_addr_ok;
  assign wr_en_b    = bus.we_b && !busy_q && wr_addr_ok;
  assign wr_any     = wr_en_a || wr_en_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else begin
      if (wr_en_a) a_mem[bus.wr_addr] <= bus.wr_data;
      if (wr_en_b) b_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read-back port (live at all times, zero for unused addresses)
  // ---------------------------------------------------------------------
  logic rd_addr_ok;
  assign rd_addr_ok = ({1'b0, bus.rd_addr} < N_L);

  always_comb begin
    bus.rd_a = '0;
    bus.rd_b = '0;
    if (rd_addr_ok) begin
      bus.rd_a = a_mem[bus.rd_addr];
      bus.rd_b = b_mem[bus.rd_addr];
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic signed [W:0]        mul_a;
  logic signed [W:0]        mul_b;
  logic [PROD_W-1:0]        prod_next;
  logic [SUM_W-1:0]         prod_ext;
  logic signed [EXT_W-1:0]  acc_ext;
  logic                     ovf_next;
  logic [ACC_W-1:0]         res_next;

  // One extra bit per operand lets a single signed multiplier serve both
  // modes: zero-extend for unsigned, sign-extend for signed. The product of
  // W-bit operands always fits in 2W bits in either mode.
  assign mul_a     = {mode_q & a_mem[idx_q][W-1], a_mem[idx_q]};
  assign mul_b     = {mode_q & b_mem[idx_q][W-1], b_mem[idx_q]};
  assign prod_next = PROD_W'(mul_a * mul_b);

  assign prod_ext  = {{(SUM_W - PROD_W){mode_q & prod_q[PROD_W-1]}}, prod_q};
  assign acc_ext   = {{(EXT_W - SUM_W){mode_q & acc_q[SUM_W-1]}}, acc_q};

  always_comb begin
    ovf_next = 1'b0;
    res_next = acc_ext[ACC_W-1:0];
    if (mode_q) begin
      ovf_next = (acc_ext > SMAX) || (acc_ext < SMIN);
    end else begin
      ovf_next = (acc_ext > UMAX);
    end
    if (ovf_next && (SAT != 0)) begin
      if (!mode_q) begin
        res_next = RES_UMAX;
      end else if (acc_ext[EXT_W-1]) begin
        res_next = RES_SMIN;
      end else begin
        res_next = RES_SMAX;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM with multiply/accumulate pipeline and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      mode_q         <= 1'b0;
      prod_q         <= '0;
      prod_vld_q     <= 1'b0;
      acc_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Vectors changed under a finished result; result/ovf keep their value.
      if (wr_any) result_valid_q <= 1'b0;

      // Accumulate stage trails the multiply stage by one edge (T2..T(N+1)).
      if (prod_vld_q) acc_q <= acc_q + prod_ext;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q     <= bus.signed_mode;
            acc_q      <= '0;
            idx_q      <= '0;
            prod_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end

        RUN: begin
          prod_q     <= prod_next;
          prod_vld_q <= 1'b1;
          if (idx_q == LAST) begin
            idx_q   <= '0;
            state_q <= DRAIN;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DRAIN: begin
          // The last product is being added this edge.
          prod_vld_q <= 1'b0;
          state_q    <= FINISH;
        end

        FINISH: begin
          result_q       <= res_next;
          ovf_q          <= ovf_next;
          result_valid_q <= 1'b1;
          done_q         <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_vec_dot_product_pipe.sv
// Purpose: self-checking bench for vec_dot_product_pipe: two N=4/W=8/ACC_W=16
//          builds (wrap and saturate) driven in lockstep plus an N=5/W=4/ACC_W=8 build.
// Latency: expects done N+2 cycles after start.
// Backpressure: checks that start/writes during busy are dropped.

module tb_vec_dot_product_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_dot_product_pipe_if #(.N(4), .W(8), .ACC_W(16)) if0 ();
  vec_dot_product_pipe_if #(.N(4), .W(8), .ACC_W(16)) if1 ();
  vec_dot_product_pipe_if #(.N(5), .W(4), .ACC_W(8))  if2 ();

  // The saturating build sees exactly the same stimulus as the wrapping one.
  assign if1.we_a        = if0.we_a;
  assign if1.we_b        = if0.we_b;
  assign if1.wr_addr     = if0.wr_addr;
  assign if1.wr_data     = if0.wr_data;
  assign if1.rd_addr     = if0.rd_addr;
  assign if1.signed_mode = if0.signed_mode;
  assign if1.start       = if0.start;

  vec_dot_product_pipe #(.N(4), .W(8), .ACC_W(16), .SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  vec_dot_product_pipe #(.N(4), .W(8), .ACC_W(16), .SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  vec_dot_product_pipe #(.N(5), .W(4), .ACC_W(8),  .SAT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int checks = 0;
  int errors = 0;

  // Reference contents of the vectors.
  int m0a [4];
  int m0b [4];
  int m2a [5];
  int m2b [5];

  // ---------------- reference model ----------------
  function automatic longint full_sum(input int sel, input bit sm);
    longint s = 0;
    longint a, b;
    int n = (sel == 0) ? 4 : 5;
    int w = (sel == 0) ? 8 : 4;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin a = m0a[i]; b = m0b[i]; end
      else          begin a = m2a[i]; b = m2b[i]; end
      if (sm && a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
      if (sm && b >= (longint'(1) << (w - 1))) b = b - (longint'(1) << w);
      s = s + a * b;
    end
    return s;
  endfunction

  function automatic longint expect_val(input longint s, input int accw, input bit sm,
                                        input bit sat, output bit ov);
    longint lo, hi, r;
    if (sm) begin
      hi = (longint'(1) << (accw - 1)) - 1;
      lo = -(longint'(1) << (accw - 1));
    end else begin
      hi = (longint'(1) << accw) - 1;
      lo = 0;
    end
    ov = (s > hi) || (s < lo);
    r  = s;
    if (ov && sat) r = (s > hi) ? hi : lo;
    return r & ((longint'(1) << accw) - 1);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int sel, input bit wa, input bit wb, input int addr, input int data);
    if (sel == 0) begin
      if0.we_a = wa; if0.we_b = wb; if0.wr_addr = addr[1:0]; if0.wr_data = data[7:0];
      if (addr < 4) begin
        if (wa) m0a[addr] = data & 255;
        if (wb) m0b[addr] = data & 255;
      end
    end else begin
      if2.we_a = wa; if2.we_b = wb; if2.wr_addr = addr[2:0]; if2.wr_data = data[3:0];
      if (addr < 5) begin
        if (wa) m2a[addr] = data & 15;
        if (wb) m2b[addr] = data & 15;
      end
    end
    @(posedge clk); #1;
    if0.we_a = 1'b0; if0.we_b = 1'b0; if2.we_a = 1'b0; if2.we_b = 1'b0;
  endtask

  // Starts a computation and returns at the falling edge where done is seen.
  // done_at counts falling edges after T0, starting at 0.
  task automatic run(input int sel, input bit sm, output int done_at, output int busy_cycles);
    logic d, b;
    if (sel == 0) begin if0.start = 1'b1; if0.signed_mode = sm; end
    else          begin if2.start = 1'b1; if2.signed_mode = sm; end
    @(posedge clk); #1;
    if0.start = 1'b0; if2.start = 1'b0;
    done_at = -1; busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      d = (sel == 0) ? if0.done : if2.done;
      b = (sel == 0) ? if0.busy : if2.busy;
      if (b) busy_cycles++;
      if (d) begin done_at = c; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if0.busy); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", if0.done); end
    checks++; if (if0.result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0", if0.result); end
    checks++; if (if0.result_valid !== 1'b0 || if0.ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got rv=%b ovf=%b want 0 0", if0.result_valid, if0.ovf); end
    for (int i = 0; i < 4; i++) begin
      if0.rd_addr = 2'(i); #1;
      checks++; if (if0.rd_a !== 8'h0 || if0.rd_b !== 8'h0) begin errors++; $display("FAIL reset_rd[%0d] got %h/%h want 0/0", i, if0.rd_a, if0.rd_b); end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int da, bc; longint s, e0, e1; bit o0, o1; logic [15:0] x0, x1;
    for (int i = 0; i < 4; i++) begin wr(0, 1, 0, i, i + 1); wr(0, 0, 1, i, i + 5); end
    run(0, 0, da, bc);
    s = full_sum(0, 0); e0 = expect_val(s, 16, 0, 0, o0); e1 = expect_val(s, 16, 0, 1, o1);
    x0 = e0[15:0]; x1 = e1[15:0];
    checks++; if (da !== 6) begin errors++; $display("FAIL basic_latency got %0d want 6", da); end
    checks++; if (bc !== 6) begin errors++; $display("FAIL basic_busy_cycles got %0d want 6", bc); end
    checks++; if (if0.result !== 16'h0046) begin errors++; $display("FAIL basic_result got %h want 0046", if0.result); end
    checks++; if (if0.ovf !== o0 || if0.result_valid !== 1'b1) begin errors++; $display("FAIL basic_flags got ovf=%b rv=%b want %b 1", if0.ovf, if0.result_valid, o0); end
    checks++; if (if1.result !== x1 || if0.result !== x0) begin errors++; $display("FAIL basic_sat_build got %h want %h", if1.result, x1); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", if0.busy); end
    @(negedge clk);
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", if0.done); end
  endtask

  task automatic check_both(input string name, input bit sm);
    longint s, e0, e1; bit o0, o1; logic [15:0] x0, x1;
    s = full_sum(0, sm); e0 = expect_val(s, 16, sm, 0, o0); e1 = expect_val(s, 16, sm, 1, o1);
    x0 = e0[15:0]; x1 = e1[15:0];
    checks++; if (if0.result !== x0 || if0.ovf !== o0) begin errors++; $display("FAIL %s_wrap got %h ovf=%b want %h ovf=%b", name, if0.result, if0.ovf, x0, o0); end
    checks++; if (if1.result !== x1 || if1.ovf !== o1) begin errors++; $display("FAIL %s_sat got %h ovf=%b want %h ovf=%b", name, if1.result, if1.ovf, x1, o1); end
  endtask

  task automatic test_overflow;
    int da, bc;
    for (int i = 0; i < 4; i++) wr(0, 1, 1, i, 255);
    run(0, 0, da, bc);
    check_both("uns_ff", 0);
    checks++; if (if0.result !== 16'hF804 || if1.result !== 16'hFFFF) begin errors++; $display("FAIL uns_ff_const got %h/%h want F804/FFFF", if0.result, if1.result); end
    wr(0, 1, 0, 0, 'hFF); wr(0, 1, 0, 1, 'h02); wr(0, 1, 0, 2, 'hFD); wr(0, 1, 0, 3, 'h04);
    for (int i = 0; i < 4; i++) wr(0, 0, 1, i, 5);
    run(0, 1, da, bc);
    check_both("signed_small", 1);
    checks++; if (if0.result !== 16'h000A || if0.ovf !== 1'b0) begin errors++; $display("FAIL signed_small_const got %h ovf=%b want 000A 0", if0.result, if0.ovf); end
    for (int i = 0; i < 4; i++) wr(0, 1, 1, i, 'h80);
    run(0, 1, da, bc);
    check_both("signed_80", 1);
    checks++; if (if1.result !== 16'h7FFF || if0.result !== 16'h0000 || if0.ovf !== 1'b1) begin errors++; $display("FAIL signed_80_const got %h/%h want 0000/7FFF", if0.result, if1.result); end
  endtask

  task automatic test_random;
    int da, bc; bit sm;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 4; i++) begin
        wr(0, 1, 0, i, int'($urandom_range(255)));
        wr(0, 0, 1, i, int'($urandom_range(255)));
      end
      sm = 1'($urandom_range(1));
      run(0, sm, da, bc);
      check_both("random", sm);
      checks++; if (da !== 6) begin errors++; $display("FAIL random_latency got %0d want 6", da); end
    end
  endtask

  task automatic test_back_to_back;
    int da, bc;
    for (int i = 0; i < 4; i++) wr(0, 1, 1, i, int'($urandom_range(255)));
    run(0, 1, da, bc);
    // Still on the falling edge where done is high: start again right away.
    run(0, 0, da, bc);
    checks++; if (da !== 6) begin errors++; $display("FAIL b2b_latency got %0d want 6", da); end
    check_both("b2b", 0);
  endtask

  task automatic test_write_with_start;
    int da = -1;
    if0.we_a = 1'b1; if0.wr_addr = 2'd2; if0.wr_data = 8'h3C; m0a[2] = 'h3C;
    if0.start = 1'b1; if0.signed_mode = 1'b0;
    @(posedge clk); #1;
    if0.we_a = 1'b0; if0.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if0.done) begin da = c; break; end
    end
    checks++; if (da !== 6) begin errors++; $display("FAIL wr_start_latency got %0d want 6", da); end
    check_both("wr_start", 0);
  endtask

  task automatic test_busy_ignore;
    int da, bc, nd = 0; logic [15:0] held; logic hovf;
    wr(0, 1, 0, 0, 'h21);
    if0.start = 1'b1; if0.signed_mode = 1'b0;
    @(posedge clk); #1; if0.start = 1'b0;
    @(posedge clk); #1;
    if0.we_a = 1'b1; if0.wr_addr = 2'd0; if0.wr_data = 8'h10; if0.start = 1'b1;
    @(posedge clk); #1;
    if0.we_a = 1'b0; if0.start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (if0.done) nd++;
    end
    checks++; if (nd !== 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", nd); end
    if0.rd_addr = 2'd0; #1;
    checks++; if (if0.rd_a !== 8'h21) begin errors++; $display("FAIL busy_write_ignored got %h want 21", if0.rd_a); end
    check_both("busy", 0);
    held = if0.result; hovf = if0.ovf;
    wr(0, 1, 0, 0, 'h10);
    checks++; if (if0.result_valid !== 1'b0) begin errors++; $display("FAIL wr_clears_rv got %b want 0", if0.result_valid); end
    checks++; if (if0.result !== held || if0.ovf !== hovf) begin errors++; $display("FAIL wr_holds_result got %h want %h", if0.result, held); end
    if0.rd_addr = 2'd0; #1;
    checks++; if (if0.rd_a !== 8'h10) begin errors++; $display("FAIL idle_write got %h want 10", if0.rd_a); end
  endtask

  task automatic test_abort;
    int da, bc, nd = 0;
    for (int i = 0; i < 4; i++) wr(0, 1, 1, i, 1);
    run(0, 0, da, bc);
    checks++; if (if0.result !== 16'h0004) begin errors++; $display("FAIL abort_pre got %h want 0004", if0.result); end
    @(posedge clk); #1;
    if0.start = 1'b1;
    @(posedge clk); #1; if0.start = 1'b0;   // T0
    @(posedge clk); @(posedge clk); @(posedge clk); #1;   // after T3
    rst_n = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin m0a[i] = 0; m0b[i] = 0; end
    for (int i = 0; i < 5; i++) begin m2a[i] = 0; m2b[i] = 0; end
    checks++; if (if0.busy !== 1'b0 || if0.result !== 16'h0 || if0.result_valid !== 1'b0) begin errors++; $display("FAIL abort_outputs got busy=%b result=%h rv=%b want 0 0 0", if0.busy, if0.result, if0.result_valid); end
    for (int i = 0; i < 4; i++) begin
      if0.rd_addr = 2'(i); #1;
      checks++; if (if0.rd_a !== 8'h0 || if0.rd_b !== 8'h0) begin errors++; $display("FAIL abort_rd[%0d] got %h/%h want 0/0", i, if0.rd_a, if0.rd_b); end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if0.done || if0.busy) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", nd); end
  endtask

  task automatic test_n5;
    int da, bc; bit sm; longint s, e; bit o; logic [7:0] x; logic [3:0] ra, rb;
    for (int i = 0; i < 5; i++) wr(2, 1, 1, i, i + 3);
    wr(2, 1, 1, 7, 9);
    for (int i = 0; i < 5; i++) begin
      if2.rd_addr = 3'(i); #1;
      ra = m2a[i][3:0]; rb = m2b[i][3:0];
      checks++; if (if2.rd_a !== ra || if2.rd_b !== rb) begin errors++; $display("FAIL n5_addr7_ignored[%0d] got %h/%h want %h/%h", i, if2.rd_a, if2.rd_b, ra, rb); end
    end
    for (int i = 0; i < 5; i++) wr(2, 1, 1, i, 15);
    run(2, 0, da, bc);
    s = full_sum(2, 0); e = expect_val(s, 8, 0, 0, o); x = e[7:0];
    checks++; if (da !== 7) begin errors++; $display("FAIL n5_latency got %0d want 7", da); end
    checks++; if (if2.result !== x || if2.ovf !== o) begin errors++; $display("FAIL n5_result got %h ovf=%b want %h ovf=%b", if2.result, if2.ovf, x, o); end
    checks++; if (if2.result !== 8'h65) begin errors++; $display("FAIL n5_const got %h want 65", if2.result); end
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 5; i++) wr(2, 1, 1, i, int'($urandom_range(15)));
      for (int i = 0; i < 5; i++) wr(2, 0, 1, i, int'($urandom_range(15)));
      sm = 1'($urandom_range(1));
      run(2, sm, da, bc);
      s = full_sum(2, sm); e = expect_val(s, 8, sm, 0, o); x = e[7:0];
      checks++; if (if2.result !== x || if2.ovf !== o) begin errors++; $display("FAIL n5_random got %h ovf=%b want %h ovf=%b", if2.result, if2.ovf, x, o); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin m0a[i] = 0; m0b[i] = 0; end
    for (int i = 0; i < 5; i++) begin m2a[i] = 0; m2b[i] = 0; end
    if0.we_a = 1'b0; if0.we_b = 1'b0; if0.wr_addr = '0; if0.wr_data = '0;
    if0.rd_addr = '0; if0.signed_mode = 1'b0; if0.start = 1'b0;
    if2.we_a = 1'b0; if2.we_b = 1'b0; if2.wr_addr = '0; if2.wr_data = '0;
    if2.rd_addr = '0; if2.signed_mode = 1'b0; if2.start = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_back_to_back();
    test_write_with_start();
    test_busy_ignore();
    test_abort();
    test_n5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
